// File: rtl/a_format_pkg.sv
// Shared definitions for the A-form decoder: unit codes, operand access
// encodings, opcode/XO constants and the per-instruction decode record.
package a_format_pkg;

    localparam logic [2:0] FU_FX = 3'd0;
    localparam logic [2:0] FU_FP = 3'd1;
    localparam logic [2:0] FU_LS = 3'd2;
    localparam logic [2:0] FU_CR = 3'd3;
    localparam logic [2:0] FU_BR = 3'd4;

    // Operand access: bit 0 = read, bit 1 = write.
    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    localparam logic [5:0] OP_X31  = 6'd31;
    localparam logic [5:0] OP_FP59 = 6'd59;
    localparam logic [5:0] OP_FP63 = 6'd63;

    localparam logic [4:0] XO_ISEL    = 5'd15;
    localparam logic [4:0] XO_FDIV    = 5'd18;
    localparam logic [4:0] XO_FSUB    = 5'd20;
    localparam logic [4:0] XO_FADD    = 5'd21;
    localparam logic [4:0] XO_FSQRT   = 5'd22;
    localparam logic [4:0] XO_FSEL    = 5'd23;
    localparam logic [4:0] XO_FRE     = 5'd24;
    localparam logic [4:0] XO_FMUL    = 5'd25;
    localparam logic [4:0] XO_FRSQRTE = 5'd26;
    localparam logic [4:0] XO_FMSUB   = 5'd28;
    localparam logic [4:0] XO_FMADD   = 5'd29;
    localparam logic [4:0] XO_FNMSUB  = 5'd30;
    localparam logic [4:0] XO_FNMADD  = 5'd31;

    localparam int CR1 = 1;

    typedef struct packed {
        logic [1:0] rw;
        logic       is_reg;
    } operand_t;

    // ops[0] is operand 1 (the target), ops[3] is operand 4.
    typedef struct packed {
        logic [2:0]     fu;
        operand_t [3:0] ops;
        logic           illegal;
    } decode_t;

endpackage

// File: rtl/a_format_decode_comb.sv
// Purely combinational A-form field decode: classifies the encoding and
// produces the operand/unit record for the first (or only) micro-op.
module a_format_decode_comb
    import a_format_pkg::*;
(
    input  logic [5:0] primary,
    input  logic [4:0] xo,
    input  logic       rc,
    input  logic [4:0] ra,
    input  logic       split_en,
    output decode_t    rec,
    output logic       is_legal,
    output logic       needs_split
);

    logic xo_fp, a_unused, b_unused, c_unused, is_fp, is_isel;

    always_comb begin
        xo_fp    = 1'b1;
        a_unused = 1'b0;
        b_unused = 1'b0;
        c_unused = 1'b0;
        case (xo)
            XO_FDIV, XO_FSUB, XO_FADD:      c_unused = 1'b1;
            XO_FSQRT, XO_FRE, XO_FRSQRTE: begin
                a_unused = 1'b1;
                c_unused = 1'b1;
            end
            XO_FMUL:                        b_unused = 1'b1;
            // fsel exists only in the double-precision opcode space
            XO_FSEL:                        xo_fp = (primary == OP_FP63);
            XO_FMSUB, XO_FMADD, XO_FNMSUB, XO_FNMADD: xo_fp = 1'b1;
            default:                        xo_fp = 1'b0;
        endcase

        is_fp   = xo_fp && ((primary == OP_FP63) || (primary == OP_FP59));
        is_isel = (primary == OP_X31) && (xo == XO_ISEL) && !rc;

        rec = '0;
        if (is_fp) begin
            rec.fu     = FU_FP;
            rec.ops[0] = '{RW_WRITE, 1'b1};
            rec.ops[1] = '{RW_READ, !a_unused};
            rec.ops[2] = '{RW_READ, !b_unused};
            rec.ops[3] = '{RW_READ, !c_unused};
        end else if (is_isel) begin
            rec.fu     = FU_FX;
            rec.ops[0] = '{RW_WRITE, 1'b1};
            // RA=0 selects the literal zero, not GPR0
            rec.ops[1] = '{RW_READ, ra != 5'd0};
            rec.ops[2] = '{RW_READ, 1'b1};
            rec.ops[3] = '{RW_NONE, 1'b0};
        end else begin
            rec.illegal = 1'b1;
        end

        is_legal    = is_fp | is_isel;
        needs_split = split_en & is_fp & rc;
    end

endmodule

// File: rtl/a_format_decode_queue.sv
// A-form decoder with a DEPTH-entry output FIFO: one instruction in per cycle,
// up to two micro-ops written per cycle when Rc=1 FP forms are split.
module a_format_decode_queue
    import a_format_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int INST_W         = 32,
    parameter int PID_W          = 20,
    parameter int TID_W          = 16,
    parameter int MAJ_ID_W       = 64,
    parameter int MIN_ID_W       = 7,
    parameter int OPCODE_W       = 12,
    parameter int REG_W          = 5,
    parameter int FU_W           = 3,
    parameter int DEPTH          = 4,
    parameter int SPLIT_RC       = 1,
    parameter int REPORT_ILLEGAL = 0
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [INST_W-1:0]        instruction_i,
    input  logic [ADDR_W-1:0]        instructionAddress_i,
    input  logic                     is64Bit_i,
    input  logic [PID_W-1:0]         instructionPid_i,
    input  logic [TID_W-1:0]         instructionTid_i,
    input  logic [MAJ_ID_W-1:0]      instructionMajId_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [OPCODE_W-1:0]      opcode_o,
    output logic                     illegal_o,
    output logic [ADDR_W-1:0]        instructionAddress_o,
    output logic                     is64Bit_o,
    output logic [PID_W-1:0]         instPid_o,
    output logic [TID_W-1:0]         instTid_o,
    output logic [MAJ_ID_W-1:0]      instMajId_o,
    output logic [MIN_ID_W-1:0]      instMinId_o,
    output logic [FU_W-1:0]          functionalUnitType_o,
    output logic [1:0]               op1rw_o,
    output logic [1:0]               op2rw_o,
    output logic [1:0]               op3rw_o,
    output logic [1:0]               op4rw_o,
    output logic                     op1IsReg_o,
    output logic                     op2IsReg_o,
    output logic                     op3IsReg_o,
    output logic                     op4IsReg_o,
    output logic [4*REG_W-1:0]       instructionBody_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CNT_W  = AW + 1;
    localparam int BODY_W = 4 * REG_W;

    decode_t             dec, dec_split;
    logic                is_legal, needs_split;
    logic [BODY_W-1:0]   body, body_split;
    logic [OPCODE_W-1:0] opcode;
    logic                accept, push1, push2, pop;
    logic [CNT_W-1:0]    count, n_push;
    logic [AW-1:0]       wr_ptr, rd_ptr, wr_ptr_nxt;

    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic                is64_q [DEPTH];
    logic [PID_W-1:0]    pid_q  [DEPTH];
    logic [TID_W-1:0]    tid_q  [DEPTH];
    logic [MAJ_ID_W-1:0] maj_q  [DEPTH];
    logic [MIN_ID_W-1:0] min_q  [DEPTH];
    decode_t             dec_q  [DEPTH];
    logic [BODY_W-1:0]   body_q [DEPTH];
    logic [OPCODE_W-1:0] opc_q  [DEPTH];

    a_format_decode_comb u_decode (
        .primary    (instruction_i[31:26]),
        .xo         (instruction_i[5:1]),
        .rc         (instruction_i[0]),
        .ra         (instruction_i[20:16]),
        .split_en   (SPLIT_RC != 0),
        .rec        (dec),
        .is_legal   (is_legal),
        .needs_split(needs_split)
    );

    assign body   = instruction_i[6 +: BODY_W];
    assign opcode = OPCODE_W'({instruction_i[31:26], instruction_i[5:0]});

    // Second micro-op of a split: CR1 target, no other operands.
    always_comb begin
        dec_split        = '0;
        dec_split.fu     = FU_CR;
        dec_split.ops[0] = '{RW_WRITE, 1'b1};
        body_split       = body;
        body_split[BODY_W-1 -: REG_W] = REG_W'(CR1);
    end

    // Two free slots are always reserved so a split never overflows.
    assign ready_o    = (count <= CNT_W'(DEPTH - 2));
    assign valid_o    = (count != '0);
    assign accept     = valid_i & ready_o;
    assign push1      = accept & (is_legal | (REPORT_ILLEGAL != 0));
    assign push2      = accept & needs_split;
    assign pop        = valid_o & ready_i;
    assign n_push     = CNT_W'(push1) + CNT_W'(push2);
    assign wr_ptr_nxt = wr_ptr + AW'(1);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                is64_q[i] <= 1'b0;
                pid_q[i]  <= '0;
                tid_q[i]  <= '0;
                maj_q[i]  <= '0;
                min_q[i]  <= '0;
                dec_q[i]  <= '0;
                body_q[i] <= '0;
                opc_q[i]  <= '0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push1) begin
                addr_q[wr_ptr] <= instructionAddress_i;
                is64_q[wr_ptr] <= is64Bit_i;
                pid_q[wr_ptr]  <= instructionPid_i;
                tid_q[wr_ptr]  <= instructionTid_i;
                maj_q[wr_ptr]  <= instructionMajId_i;
                min_q[wr_ptr]  <= '0;
                dec_q[wr_ptr]  <= dec;
                body_q[wr_ptr] <= body;
                opc_q[wr_ptr]  <= opcode;
            end
            if (push2) begin
                addr_q[wr_ptr_nxt] <= instructionAddress_i;
                is64_q[wr_ptr_nxt] <= is64Bit_i;
                pid_q[wr_ptr_nxt]  <= instructionPid_i;
                tid_q[wr_ptr_nxt]  <= instructionTid_i;
                maj_q[wr_ptr_nxt]  <= instructionMajId_i;
                min_q[wr_ptr_nxt]  <= MIN_ID_W'(1);
                dec_q[wr_ptr_nxt]  <= dec_split;
                body_q[wr_ptr_nxt] <= body_split;
                opc_q[wr_ptr_nxt]  <= opcode;
            end
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + n_push - CNT_W'(pop);
        end
    end

    assign count_o              = count;
    assign opcode_o             = opc_q[rd_ptr];
    assign illegal_o            = dec_q[rd_ptr].illegal;
    assign instructionAddress_o = addr_q[rd_ptr];
    assign is64Bit_o            = is64_q[rd_ptr];
    assign instPid_o            = pid_q[rd_ptr];
    assign instTid_o            = tid_q[rd_ptr];
    assign instMajId_o          = maj_q[rd_ptr];
    assign instMinId_o          = min_q[rd_ptr];
    assign functionalUnitType_o = FU_W'(dec_q[rd_ptr].fu);
    assign op1rw_o              = dec_q[rd_ptr].ops[0].rw;
    assign op2rw_o              = dec_q[rd_ptr].ops[1].rw;
    assign op3rw_o              = dec_q[rd_ptr].ops[2].rw;
    assign op4rw_o              = dec_q[rd_ptr].ops[3].rw;
    assign op1IsReg_o           = dec_q[rd_ptr].ops[0].is_reg;
    assign op2IsReg_o           = dec_q[rd_ptr].ops[1].is_reg;
    assign op3IsReg_o           = dec_q[rd_ptr].ops[2].is_reg;
    assign op4IsReg_o           = dec_q[rd_ptr].ops[3].is_reg;
    assign instructionBody_o    = body_q[rd_ptr];

endmodule

// File: doc/a_format_decode_queue.md
Name: a_format_decode_queue

Overview:
- Parametrised successor to the A-format decoder: decodes one A-form instruction per cycle (primary opcodes 31, 59, 63) into the common decoded-instruction record.
- Adds a DEPTH-entry output FIFO with valid/ready back-pressure, Rc=1 micro-op splitting, optional illegal-instruction reporting, and flush.
- Sits between the format classifier and the rename/dispatch stage of decode.

Parameters:
ADDR_W, 64, instruction address width
INST_W, 32, instruction width
PID_W, 20, process ID width
TID_W, 16, thread ID width
MAJ_ID_W, 64, major instruction ID width
MIN_ID_W, 7, minor (micro-op) ID width
OPCODE_W, 12, decoded opcode width
REG_W, 5, register specifier width
FU_W, 3, functional-unit code width
DEPTH, 4, output FIFO entries; power of two, >=2
SPLIT_RC, 1, 1 = Rc=1 FP forms emit a second CR micro-op
REPORT_ILLEGAL, 0, 1 = non-A-form encodings are enqueued with illegal_o=1; 0 = dropped

Ports:
clock_i  in  1  clock
reset_i  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous pipeline flush
valid_i  in  1  input instruction valid
ready_o  out  1  input accepted when valid_i & ready_o
instruction_i  in  INST_W  raw instruction
instructionAddress_i  in  ADDR_W  instruction address
is64Bit_i  in  1  64-bit mode
instructionPid_i  in  PID_W  process ID
instructionTid_i  in  TID_W  thread ID
instructionMajId_i  in  MAJ_ID_W  major ID
valid_o  out  1  FIFO head valid
ready_i  in  1  consumer takes head when valid_o & ready_i
opcode_o  out  OPCODE_W  {primary[6], XO[5], Rc}
illegal_o  out  1  head is an undecodable instruction
instructionAddress_o, is64Bit_o, instPid_o, instTid_o, instMajId_o  out  as inputs  passthrough
instMinId_o  out  MIN_ID_W  micro-op index
functionalUnitType_o  out  FU_W  FX=0, FP=1, CR=3
op1rw_o..op4rw_o  out  2 each  [0]=read, [1]=write
op1IsReg_o..op4IsReg_o  out  1 each  operand is a register
instructionBody_o  out  4*REG_W  instruction bits 6..25
count_o  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (reset_i=0, asynchronous): FIFO empty, count_o=0, valid_o=0, all head fields 0, ready_o=1 after release.
- Legal set: op 63 XO {18,20,21,22,23,24,25,26,28,29,30,31} (12); op 59 XO {18,20,21,22,24,25,26,28,29,30,31} (11); op 31 XO 15 with bit31=0 (isel) (1); 24 in total. Everything else is illegal.
- FP forms: FU=1; op1 FRT write(2'b10... encoded [1]=1), op2 FRA read, op3 FRB read, op4 FRC read.
- FP operand IsReg=0 where unused: FRC for fadd/fsub/fdiv forms, FRB for fmul forms, FRA+FRC for fsqrt/fre/frsqrte, none unused otherwise.
- isel: FU=0; op1 RT write, op3 RB read, op2 RA read with IsReg=0 when RA=0, op4 BC IsReg=0 rw=0.
- ready_o = (DEPTH - count) >= 2, combinational from registered count only; ready_o never depends on valid_i.
- Latency: accepted at edge N -> visible at head at edge N+1 if FIFO was empty; no combinational input-to-output path.
- SPLIT_RC=1, FP form with Rc=1: two entries written in the same cycle.
  - Entry 1: minId 0, FU=1.
  - Entry 2: minId 1, FU=3, op1=CR1 (REG_W'd1) write, op2..op4 IsReg=0 rw=0, same majId/address/opcode.
  - Otherwise one entry with minId 0.
- Illegal encoding: REPORT_ILLEGAL=1 -> one entry, illegal_o=1, FU=0, all IsReg=0, rw=0. REPORT_ILLEGAL=0 -> accepted (handshake completes) but nothing enqueued.
- Pop and push in the same cycle are allowed; count updates by pushes - pops.
- Pointers wrap modulo DEPTH.
- flush_i=1: FIFO emptied at the next edge. A same-cycle input or pop is discarded; flush wins. valid_o=0 the following cycle.
- valid_o=0 -> head fields hold their last value; the bench must not check them.

Decomposition:
- Shared package a_format_pkg:
  - FU codes (FX/FP/CR/LS/Branch)
  - rw encodings
  - primary opcode constants 31/59/63
  - XO constants
  - decoded-record struct/width constants
- Sub-module a_format_decode_comb: purely combinational field decode producing one record plus is_legal and needs_split.
- Top level holds the FIFO, handshake and split-write logic.

Test Plan:
- Sweep all 64 primary opcodes x 32 XO with Rc=0, ready_i=1, REPORT_ILLEGAL=0 -> exactly 24 entries popped; fadd (63/21) gives FU=1, opcode_o=12'b111111_10101_0.
- fmadds (59/29) Rc=1, SPLIT_RC=1 -> two consecutive entries, minId 0 FU=1 then minId 1 FU=3 op1=1, same majId; count_o=2 before pops.
- isel with RA=0, RB=5 -> FU=0, op2IsReg=0, op3IsReg=1 op3rw=read, op4IsReg=0.
- ready_i=0, push single-uop instructions -> ready_o drops when count_o=DEPTH-1; resume ready_i=1 -> pops return in order with matching majIds.
- Full FIFO plus flush_i=1 with valid_i=1 -> next cycle count_o=0, valid_o=0, flushed input never appears.
- Assert reset_i=0 mid-stream between clock edges -> valid_o and count_o go to 0 immediately; REPORT_ILLEGAL=1 with opcode 0 afterwards -> one entry with illegal_o=1.
